// File: rtl/genius_game_controller.sv
// Genius (Simon) round controller: plays back the first N colours of the
// sequence store, then checks the player's presses against the same entries.
module genius_game_controller #(
   parameter int unsigned ON_TICKS      = 25_000_000,
   parameter int unsigned OFF_TICKS     = 12_500_000,
   parameter int unsigned TIMEOUT_TICKS = 250_000_000,
   parameter int unsigned MAX_ROUND     = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [2:0] buttons,
   input  logic [1:0] current_sequence_number,
   output logic [3:0] sequence_count,
   output logic [2:0] leds,
   output logic [4:0] round_number,
   output logic       player_turn,
   output logic       win,
   output logic       lose
);

   localparam int unsigned TMAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int unsigned TMAX  = (TMAX0 > TIMEOUT_TICKS) ? TMAX0 : TIMEOUT_TICKS;
   localparam int unsigned TW    = $clog2(TMAX + 1);

   localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
   localparam logic [4:0]    MAX_R    = 5'(MAX_ROUND);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SHOW_ON, S_SHOW_OFF, S_WAIT, S_PAUSE, S_WIN, S_LOSE
   } state_e;

   typedef enum logic {M_SHOW, M_CHECK} mode_e;

   state_e        state_q, state_d;
   mode_e         mode_q, mode_d;
   logic [3:0]    idx_q, idx_d;
   logic [1:0]    digit_q, digit_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [3:0]    seq_q, seq_d;
   logic [4:0]    round_q, round_d;
   logic [3:0]    last_idx;

   // colour 3 has no LED, so it maps to 000 and can never match a press
   function automatic logic [2:0] onehot(input logic [1:0] c);
      case (c)
         2'd0:    onehot = 3'b001;
         2'd1:    onehot = 3'b010;
         2'd2:    onehot = 3'b100;
         default: onehot = 3'b000;
      endcase
   endfunction

   assign last_idx = 4'(round_q - 5'd1);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         mode_q  <= M_SHOW;
         idx_q   <= '0;
         digit_q <= '0;
         tick_q  <= '0;
         seq_q   <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         tick_q  <= tick_d;
         seq_q   <= seq_d;
         round_q <= round_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      digit_d = digit_q;
      tick_d  = tick_q;
      seq_d   = seq_q;
      round_d = round_q;
      if (start) begin
         state_d = S_FETCH;
         mode_d  = M_SHOW;
         idx_d   = '0;
         seq_d   = '0;
         tick_d  = '0;
         round_d = 5'd1;
      end else begin
         case (state_q)
            // two cycles: address goes out on entry, data is back on the 2nd edge
            S_FETCH: begin
               if (tick_q == '0) begin
                  tick_d = TW'(1);
               end else begin
                  tick_d  = '0;
                  digit_d = current_sequence_number;
                  state_d = (mode_q == M_SHOW) ? S_SHOW_ON : S_WAIT;
               end
            end
            S_SHOW_ON: begin
               if (tick_q == ON_LAST) begin
                  tick_d  = '0;
                  state_d = S_SHOW_OFF;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_SHOW_OFF: begin
               if (tick_q == OFF_LAST) begin
                  tick_d  = '0;
                  state_d = S_FETCH;
                  if (idx_q == last_idx) begin
                     idx_d  = '0;
                     mode_d = M_CHECK;
                     seq_d  = '0;
                  end else begin
                     idx_d = idx_q + 4'd1;
                     seq_d = idx_q + 4'd1;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_WAIT: begin
               if (buttons != 3'b000) begin
                  tick_d = '0;
                  if (buttons != onehot(digit_q)) begin
                     state_d = S_LOSE;
                  end else if (idx_q != last_idx) begin
                     idx_d   = idx_q + 4'd1;
                     seq_d   = idx_q + 4'd1;
                     state_d = S_FETCH;
                  end else if (round_q == MAX_R) begin
                     state_d = S_WIN;
                  end else begin
                     round_d = round_q + 5'd1;
                     idx_d   = '0;
                     mode_d  = M_SHOW;
                     state_d = S_PAUSE;
                  end
               end else if (tick_q == TO_LAST) begin
                  tick_d  = '0;
                  state_d = S_LOSE;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_PAUSE: begin
               if (tick_q == OFF_LAST) begin
                  tick_d  = '0;
                  seq_d   = idx_q;
                  state_d = S_FETCH;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      leds = 3'b000;
      if (state_q == S_SHOW_ON) leds = onehot(digit_q);
      else if (state_q == S_WIN) leds = 3'b111;
   end

   assign sequence_count = seq_q;
   assign round_number   = round_q;
   assign player_turn    = (state_q == S_WAIT);
   assign win            = (state_q == S_WIN);
   assign lose           = (state_q == S_LOSE);

endmodule

// File: tb/tb_genius_game_controller.sv
// Bench for genius_game_controller: scoreboard of expected playback colours
// plus directed checks of turn, round, win and lose behaviour.
module tb_genius_game_controller;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [2:0] buttons;
   logic [1:0] csn;
   logic [3:0] sequence_count;
   logic [2:0] leds;
   logic [4:0] round_number;
   logic       player_turn;
   logic       win;
   logic       lose;

   int total = 0;
   int bad   = 0;

   logic [1:0] tbl [16] = '{2, 1, 0, 1, 0, 2, 0, 1, 2, 2, 1, 0, 0, 1, 2, 1};

   typedef struct {
      logic [2:0] col;
      logic [3:0] addr;
   } exp_t;
   exp_t exp_q[$];

   bit         mon_en = 0;
   logic [2:0] prev   = 3'b000;
   int         len    = 0;

   genius_game_controller #(
      .ON_TICKS(4), .OFF_TICKS(2), .TIMEOUT_TICKS(20), .MAX_ROUND(3)
   ) dut (
      .clock(clk),
      .reset_n(reset_n),
      .start(start),
      .buttons(buttons),
      .current_sequence_number(csn),
      .sequence_count(sequence_count),
      .leds(leds),
      .round_number(round_number),
      .player_turn(player_turn),
      .win(win),
      .lose(lose)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // sequence store with one cycle of read latency
   always @(posedge clk) csn <= tbl[sequence_count];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] oh(input logic [1:0] c);
      case (c)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
   endfunction

   task automatic push_round(input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.col  = oh(tbl[i]);
         e.addr = 4'(i);
         exp_q.push_back(e);
      end
   endtask

   // each playback colour: popped on its rising edge, length checked on its fall
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev == 3'b000 && leds != 3'b000) begin
            if (exp_q.size() == 0) begin
               check("unexp_led", {29'd0, leds}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("led_col", {29'd0, leds}, {29'd0, e.col});
               check("led_addr", {28'd0, sequence_count}, {28'd0, e.addr});
            end
            len = 1;
         end else if (leds != 3'b000) begin
            len++;
         end else if (prev != 3'b000 && prev != 3'b111) begin
            check("led_len", len, 4);
         end
      end
      prev = leds;
   end

   task automatic wait_turn(input string tag);
      int n = 0;
      while (!player_turn && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, player_turn}, 32'd1);
   endtask

   task automatic press(input logic [2:0] b);
      buttons = b;
      @(negedge clk);
      buttons = 3'b000;
   endtask

   task automatic pulse_start();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   initial begin
      reset_n = 0;
      start   = 0;
      buttons = 0;
      repeat (3) @(negedge clk);
      check("rst_leds",  {29'd0, leds}, 0);
      check("rst_round", {27'd0, round_number}, 0);
      check("rst_seq",   {28'd0, sequence_count}, 0);
      check("rst_turn",  {31'd0, player_turn}, 0);
      check("rst_win",   {31'd0, win}, 0);
      check("rst_lose",  {31'd0, lose}, 0);
      pulse_start();
      check("rst_ovr_round", {27'd0, round_number}, 0);
      reset_n = 1;
      @(negedge clk);

      // reset in the middle of the first colour
      pulse_start();
      for (int n = 0; n < 20 && leds == 3'b000; n++) @(negedge clk);
      check("mid_lit", {31'd0, leds != 3'b000}, 1);
      @(negedge clk);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      check("mid_rst_leds",  {29'd0, leds}, 0);
      check("mid_rst_round", {27'd0, round_number}, 0);
      check("mid_rst_seq",   {28'd0, sequence_count}, 0);
      @(negedge clk);
      check("idle_leds", {29'd0, leds}, 0);
      mon_en = 1;

      // round 1 with exact playback timing
      push_round(1);
      pulse_start();
      check("r1_n0_leds", {29'd0, leds}, 0);
      check("r1_round",   {27'd0, round_number}, 1);
      @(negedge clk);
      check("r1_n1_leds", {29'd0, leds}, 0);
      @(negedge clk);
      check("r1_n2_leds", {29'd0, leds}, 3'b100);
      repeat (4) @(negedge clk);
      check("r1_off0", {29'd0, leds}, 0);
      @(negedge clk);
      check("r1_off1", {29'd0, leds}, 0);
      repeat (2) @(negedge clk);
      check("r1_turn_early", {31'd0, player_turn}, 0);
      @(negedge clk);
      check("r1_turn", {31'd0, player_turn}, 1);
      check("r1_seq",  {28'd0, sequence_count}, 0);
      push_round(2);
      press(3'b100);
      check("r2_round", {27'd0, round_number}, 2);
      check("r2_turn0", {31'd0, player_turn}, 0);

      // round 2: right then wrong colour
      wait_turn("r2a_turn");
      check("r2a_seq", {28'd0, sequence_count}, 0);
      press(3'b100);
      wait_turn("r2b_turn");
      check("r2b_seq", {28'd0, sequence_count}, 1);
      press(3'b001);
      check("wrong_lose",  {31'd0, lose}, 1);
      check("wrong_turn",  {31'd0, player_turn}, 0);
      check("wrong_round", {27'd0, round_number}, 2);
      press(3'b010);
      check("late_lose",  {31'd0, lose}, 1);
      check("late_round", {27'd0, round_number}, 2);
      check("late_seq",   {28'd0, sequence_count}, 1);

      // timeout
      push_round(1);
      pulse_start();
      check("restart_lose", {31'd0, lose}, 0);
      wait_turn("to_turn");
      repeat (19) @(negedge clk);
      check("to_19_lose", {31'd0, lose}, 0);
      check("to_19_turn", {31'd0, player_turn}, 1);
      @(negedge clk);
      check("to_20_lose", {31'd0, lose}, 1);
      check("to_20_turn", {31'd0, player_turn}, 0);

      // multi-bit press
      push_round(1);
      pulse_start();
      wait_turn("mb_turn");
      press(3'b110);
      check("mb_lose",  {31'd0, lose}, 1);
      check("mb_round", {27'd0, round_number}, 1);

      // full game to MAX_ROUND=3
      push_round(1);
      pulse_start();
      for (int r = 1; r <= 3; r++) begin
         for (int i = 0; i < r; i++) begin
            wait_turn("win_turn");
            if (i == r - 1) begin
               if (r < 3) push_round(r + 1);
               else begin
                  exp_t e;
                  e.col  = 3'b111;
                  e.addr = 4'd2;
                  exp_q.push_back(e);
               end
            end
            press(oh(tbl[i]));
         end
      end
      check("win_win",   {31'd0, win}, 1);
      check("win_leds",  {29'd0, leds}, 3'b111);
      check("win_round", {27'd0, round_number}, 3);
      check("win_lose",  {31'd0, lose}, 0);
      check("win_turn",  {31'd0, player_turn}, 0);
      press(3'b100);
      check("win_hold", {31'd0, win}, 1);

      // start and a button in the same cycle: restart wins
      push_round(1);
      start   = 1;
      buttons = 3'b100;
      @(negedge clk);
      start   = 0;
      buttons = 3'b000;
      check("rs_round", {27'd0, round_number}, 1);
      check("rs_win",   {31'd0, win}, 0);
      check("rs_leds",  {29'd0, leds}, 0);
      wait_turn("rs_turn");
      check("rs_seq", {28'd0, sequence_count}, 0);
      check("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
